debug_snapshot: RTL and testbench
=================================

# debug_snapshot

Captures a coherent snapshot of the 64-entry CPU debug space (register file entries 0–31 plus pipeline/datapath probes 32–63) into a local buffer. It sits directly upstream of the debug datapath mux. It drives `debug_addr`, samples the returned `debug_data` one entry at a time, and serves the frozen copy to the display/VGA reader through a synchronous read port. When idle it passes a live address through, so the display can still watch signals in real time.

## Interface
- `ADDR_W`, 6, debug address width; buffer depth is 2^ADDR_W.
- `DATA_W`, 32, debug data width.
- `SETTLE`, 1, wait cycles after each `debug_addr` change before sampling (0 allowed).

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a snapshot.
- `live_addr`  in  ADDR_W  address forwarded to `debug_addr` when not scanning.
- `debug_addr`  out  ADDR_W  address presented to the debug datapath mux.
- `debug_data`  in  DATA_W  combinational response to `debug_addr`.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  one-cycle pulse when the last entry has been written.
- `snap_valid`  out  1  buffer holds a complete snapshot.
- `rd_addr`  in  ADDR_W  buffer read address.
- `rd_data`  out  DATA_W  buffer contents at `rd_addr`, registered.

## Operation
- FSM states: IDLE, WAIT, CAPT, DONE.
  - IDLE: `start`=1 → WAIT. Also: `idx`←0, `settle_cnt`←0, `snap_valid`←0.
  - WAIT: if `settle_cnt`==SETTLE → CAPT; otherwise `settle_cnt`++. When SETTLE=0, WAIT lasts exactly one cycle.
  - CAPT: write `debug_data` to `buf[idx]`. If `idx`==2^ADDR_W−1 → DONE. Otherwise `idx`++, `settle_cnt`←0, → WAIT.
  - DONE: `done`=1 for this cycle only, `snap_valid`←1, → IDLE.
- `debug_addr` is `idx` in WAIT/CAPT and `live_addr` in IDLE/DONE (combinational mux).
- `busy` = (state is WAIT or CAPT).
- `start` in any state other than IDLE is ignored (no queuing).
- `idx` is ADDR_W bits wide; the terminal test happens before the increment, so the counter never wraps.
- Read port: `rd_data` ← `buf[rd_addr]` every cycle. Reads stay live during a scan. A write and a read to the same address in the same cycle return the old data (read-first).

## Timing
- Reset values: state=IDLE, `idx`=0, `settle_cnt`=0, `busy`=0, `done`=0, `snap_valid`=0, `rd_data`=0. Buffer contents are not cleared.
- Reset asserted mid-scan: the FSM returns to IDLE immediately and `snap_valid` stays 0. The partially written buffer is left as is.
- Snapshot latency: `start` sampled at edge 0 → `done` high during cycle 2^ADDR_W·(SETTLE+2)+1 after it. With defaults: 64·3 = 192 cycles in WAIT/CAPT, then 1 cycle DONE.
- Each entry is presented on `debug_addr` for SETTLE+2 cycles (SETTLE+1 in WAIT, 1 in CAPT). It is sampled at the end of CAPT.
- `rd_data` latency: 1 cycle from `rd_addr`.
- `snap_valid` rises together with the `done` edge, i.e. it is visible the cycle after DONE and stays high until the next `start` is accepted.

## Structure
- Shared header `debug_defs`: `DBG_ADDR_W`, `DBG_DATA_W`, and the FSM state encodings (2-bit: IDLE=0, WAIT=1, CAPT=2, DONE=3).
- Sub-module `snapshot_ram`: 2^ADDR_W × DATA_W, one synchronous write port and one synchronous read-first read port. Inferable as distributed or block RAM.
- The top level holds the FSM, the `idx`/`settle_cnt` counters and the `debug_addr` mux.

## Test plan
- Reset then idle: `live_addr`=0x25 → `debug_addr`=0x25, `busy`=0, `snap_valid`=0, `rd_data`=0.
- Full scan, SETTLE=1: model returns `debug_data`=0xA500_0000|addr → `done` pulses exactly 193 cycles after `start`. After that, `rd_addr`=0x3F reads 0xA500_003F and `rd_addr`=0 reads 0xA500_0000.
- SETTLE=0: the model's response lags `debug_addr` by 0 cycles → `done` at cycle 129. Every `debug_addr` value 0..63 appears for exactly 2 cycles.
- `start` held high for the whole scan, plus an extra `start` pulse during DONE → exactly one `done` pulse and no second scan. The FSM is in IDLE the cycle after DONE.
- Reset asserted at scan cycle 50 → `busy`=0 and `debug_addr`=`live_addr` immediately, `snap_valid`=0. A following `start` completes normally.
- Read during scan: `rd_addr`=5 held; entry 5 is written at its CAPT edge → `rd_data` shows the old value on that edge and the new value one cycle later.

Source files
------------

// File: rtl/debug_snapshot_pkg.sv
// Shared debug-space definitions: address/data widths and snapshot FSM state encodings.
package debug_snapshot_pkg;

  localparam int DBG_ADDR_W = 6;
  localparam int DBG_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2,
    S_DONE = 2'd3
  } snap_state_t;

endpackage

// File: rtl/debug_snapshot_ram.sv
// Snapshot buffer: one synchronous write port and one registered read-first read port.
module snapshot_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset so the array maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/debug_snapshot.sv
// Walks the whole debug address space, captures each returned word into a local
// buffer, and forwards the live address to the debug mux whenever it is not scanning.
module debug_snapshot
  import debug_snapshot_pkg::*;
#(
  parameter int ADDR_W = DBG_ADDR_W,
  parameter int DATA_W = DBG_DATA_W,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] live_addr,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data,
  output logic              busy,
  output logic              done,
  output logic              snap_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0]  SETTLE_C = CNT_W'(SETTLE);
  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  snap_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              snap_valid_reg, snap_valid_next;
  logic              wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      snap_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      snap_valid_reg <= snap_valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    cnt_next        = cnt_reg;
    snap_valid_next = snap_valid_reg;
    wr_en           = 1'b0;
    case (state_reg)
      S_IDLE: begin
        idx_next = '0;
        cnt_next = '0;
        // The old snapshot stays valid until a new scan actually begins.
        if (start) begin
          snap_valid_next = 1'b0;
          state_next      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_reg == SETTLE_C) begin
          state_next = S_CAPT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_CAPT: begin
        wr_en = 1'b1;
        // Terminal test precedes the increment, so idx never wraps.
        if (idx_reg == IDX_LAST) begin
          state_next = S_DONE;
        end else begin
          idx_next   = idx_reg + 1'b1;
          cnt_next   = '0;
          state_next = S_WAIT;
        end
      end
      S_DONE: begin
        snap_valid_next = 1'b1;
        state_next      = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy       = (state_reg == S_WAIT) || (state_reg == S_CAPT);
  assign done       = (state_reg == S_DONE);
  assign snap_valid = snap_valid_reg;
  assign debug_addr = busy ? idx_reg : live_addr;

  snapshot_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (idx_reg),
    .wr_data (debug_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_debug_snapshot.sv
// Directed checks of debug_snapshot with SETTLE=1 (instance a) and SETTLE=0 (instance b).
module tb_debug_snapshot;

  logic        clk = 1'b0;
  logic        rst;

  logic        start_a, busy_a, done_a, snap_valid_a;
  logic [5:0]  live_addr_a, debug_addr_a, rd_addr_a;
  logic [31:0] debug_data_a, rd_data_a, base_a;

  logic        start_b, busy_b, done_b, snap_valid_b;
  logic [5:0]  live_addr_b, debug_addr_b, rd_addr_b;
  logic [31:0] debug_data_b, rd_data_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign debug_data_a = base_a | {26'd0, debug_addr_a};
  assign debug_data_b = 32'h5A00_0000 | {26'd0, debug_addr_b};

  debug_snapshot #(.ADDR_W(6), .DATA_W(32), .SETTLE(1)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start_a),
    .live_addr  (live_addr_a),
    .debug_addr (debug_addr_a),
    .debug_data (debug_data_a),
    .busy       (busy_a),
    .done       (done_a),
    .snap_valid (snap_valid_a),
    .rd_addr    (rd_addr_a),
    .rd_data    (rd_data_a)
  );

  debug_snapshot #(.ADDR_W(6), .DATA_W(32), .SETTLE(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start_b),
    .live_addr  (live_addr_b),
    .debug_addr (debug_addr_b),
    .debug_data (debug_data_b),
    .busy       (busy_b),
    .done       (done_b),
    .snap_valid (snap_valid_b),
    .rd_addr    (rd_addr_b),
    .rd_data    (rd_data_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int k;
  int done_cnt;
  int busy_after;
  int addr_hits [64];
  int bad_hits;

  initial begin
    rst = 1'b1;
    start_a = 1'b0; live_addr_a = 6'h25; rd_addr_a = 6'h00; base_a = 32'hA500_0000;
    start_b = 1'b0; live_addr_b = 6'h11; rd_addr_b = 6'h00;
    step(); step();

    // Reset state (rd_data sampled while reset still holds it at zero)
    chk("rst_debug_addr", {26'd0, debug_addr_a}, 32'h25);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_snap_valid", {31'd0, snap_valid_a}, 32'd0);
    chk("rst_rd_data", rd_data_a, 32'd0);
    rst = 1'b0;
    step();
    live_addr_a = 6'h2A;
    #1;
    chk("idle_live_pass", {26'd0, debug_addr_a}, 32'h2A);

    // Scan 1: SETTLE=1, done expected in cycle 193
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    k = 1;
    chk("scan1_busy", {31'd0, busy_a}, 32'd1);
    chk("scan1_addr0", {26'd0, debug_addr_a}, 32'd0);
    while (!done_a && k < 400) begin
      step();
      k++;
    end
    chk("scan1_done_cycle", k, 32'd193);
    chk("scan1_busy_in_done", {31'd0, busy_a}, 32'd0);
    chk("scan1_live_in_done", {26'd0, debug_addr_a}, 32'h2A);
    step();
    chk("scan1_done_pulse", {31'd0, done_a}, 32'd0);
    chk("scan1_snap_valid", {31'd0, snap_valid_a}, 32'd1);
    rd_addr_a = 6'h3F;
    step();
    chk("scan1_rd_3f", rd_data_a, 32'hA500_003F);
    rd_addr_a = 6'h00;
    step();
    chk("scan1_rd_00", rd_data_a, 32'hA500_0000);

    // Scan 2: start held throughout plus DONE; new data; read-during-scan on entry 5
    base_a = 32'h7700_0000;
    rd_addr_a = 6'h05;
    start_a = 1'b1;
    step();
    k = 1;
    chk("scan2_snap_cleared", {31'd0, snap_valid_a}, 32'd0);
    while (!done_a && k < 400) begin
      if (k == 18) begin
        chk("scan2_capt5_addr", {26'd0, debug_addr_a}, 32'h05);
        chk("scan2_rd_before", rd_data_a, 32'hA500_0005);
      end
      if (k == 19) chk("scan2_rd_old_at_write", rd_data_a, 32'hA500_0005);
      if (k == 20) chk("scan2_rd_new", rd_data_a, 32'h7700_0005);
      step();
      k++;
    end
    chk("scan2_done_cycle", k, 32'd193);
    step();
    start_a = 1'b0;
    chk("scan2_idle_after_done", {31'd0, busy_a}, 32'd0);
    done_cnt = 0;
    busy_after = 0;
    for (int i = 0; i < 250; i++) begin
      if (done_a) done_cnt++;
      if (busy_a) busy_after++;
      step();
    end
    chk("scan2_no_second_done", done_cnt, 32'd0);
    chk("scan2_no_second_scan", busy_after, 32'd0);
    chk("scan2_snap_valid", {31'd0, snap_valid_a}, 32'd1);

    // Scan 3 interrupted by reset at scan cycle 50
    base_a = 32'hC300_0000;
    live_addr_a = 6'h33;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    k = 1;
    while (k < 50) begin
      step();
      k++;
    end
    chk("scan3_busy_before_rst", {31'd0, busy_a}, 32'd1);
    rst = 1'b1;
    #1;
    chk("scan3_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("scan3_rst_live", {26'd0, debug_addr_a}, 32'h33);
    chk("scan3_rst_snap_valid", {31'd0, snap_valid_a}, 32'd0);
    step();
    rst = 1'b0;
    step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    k = 1;
    while (!done_a && k < 400) begin
      step();
      k++;
    end
    chk("scan4_done_cycle", k, 32'd193);
    rd_addr_a = 6'h10;
    step();
    chk("scan4_snap_valid", {31'd0, snap_valid_a}, 32'd1);
    chk("scan4_rd_10", rd_data_a, 32'hC300_0010);

    // SETTLE=0 on instance b: done in cycle 129, each address held 2 cycles
    for (int i = 0; i < 64; i++) addr_hits[i] = 0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    k = 1;
    while (!done_b && k < 400) begin
      if (busy_b) addr_hits[debug_addr_b]++;
      step();
      k++;
    end
    chk("b_done_cycle", k, 32'd129);
    bad_hits = 0;
    for (int i = 0; i < 64; i++) if (addr_hits[i] != 2) bad_hits++;
    chk("b_addr_hold_2", bad_hits, 32'd0);
    rd_addr_b = 6'h2C;
    step();
    step();
    chk("b_rd_2c", rd_data_b, 32'h5A00_002C);
    chk("b_snap_valid", {31'd0, snap_valid_b}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
